// File: rtl/scrambler_pkg.sv
// Shared types and step functions for the G(x) = 1 + x^39 + x^58 self-synchronous
// scrambler. Bits are handled in wire order: data bit i is the i-th bit on the
// wire, and LFSR bit k holds the wire bit k+1 positions in the past.
package scrambler_pkg;

  localparam int LFSR_W = 58;
  localparam int TAP_A  = 39;
  localparam int TAP_B  = 58;
  localparam int MAX_W  = 128;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t LFSR_SEED_DEFAULT = '1;

  // {next_state, result}; result is LSB-aligned, bits at or above width are zero.
  typedef struct packed {
    lfsr_t            next_state;
    logic [MAX_W-1:0] result;
  } step_t;

  // hist lays the 58 past bits and the new word out as one line: hist[p] for
  // p < 58 is the past (hist[57] newest), hist[58+i] is word bit i. Both taps
  // are then fixed offsets back from the current bit, and the next state is
  // simply the newest 58 entries, which also covers widths below 58.
  function automatic step_t scr_step(lfsr_t state, logic [MAX_W-1:0] data, int width);
    logic [LFSR_W+MAX_W-1:0] hist;
    step_t                   r;
    hist = '0;
    r    = '0;
    for (int p = 0; p < LFSR_W; p++) hist[p] = state[LFSR_W-1-p];
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        hist[LFSR_W+i] = data[i] ^ hist[LFSR_W-TAP_A+i] ^ hist[LFSR_W-TAP_B+i];
        r.result[i]    = hist[LFSR_W+i];
      end
    end
    for (int k = 0; k < LFSR_W; k++) r.next_state[k] = hist[LFSR_W-1+width-k];
    return r;
  endfunction

  // Feed-forward inverse: history comes from the received (scrambled) bits.
  function automatic step_t dscr_step(lfsr_t state, logic [MAX_W-1:0] data, int width);
    logic [LFSR_W+MAX_W-1:0] hist;
    step_t                   r;
    hist = '0;
    r    = '0;
    for (int p = 0; p < LFSR_W; p++) hist[p] = state[LFSR_W-1-p];
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        hist[LFSR_W+i] = data[i];
        r.result[i]    = data[i] ^ hist[LFSR_W-TAP_A+i] ^ hist[LFSR_W-TAP_B+i];
      end
    end
    for (int k = 0; k < LFSR_W; k++) r.next_state[k] = hist[LFSR_W-1+width-k];
    return r;
  endfunction

endpackage

// File: rtl/scrambler_core.sv
// Combinational scrambler/descrambler step for one DATA_W-bit word in wire order.
//   state      : current LFSR state
//   din        : input word (wire order)
//   next_state : LFSR state after this word
//   dout       : scrambled (or descrambled) word
module scrambler_core
  import scrambler_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter bit DESCRAMBLE = 1'b0
) (
  input  lfsr_t             state,
  input  logic [DATA_W-1:0] din,
  output lfsr_t             next_state,
  output logic [DATA_W-1:0] dout
);

  if (DATA_W < 8 || DATA_W > MAX_W) begin : g_bad_width
    $error("scrambler_core: DATA_W must be in 8..128");
  end

  step_t            step;
  logic [MAX_W-1:0] din_ext;

  assign din_ext = MAX_W'(din);

  if (DESCRAMBLE) begin : g_dscr
    assign step = dscr_step(state, din_ext, DATA_W);
  end else begin : g_scr
    assign step = scr_step(state, din_ext, DATA_W);
  end

  assign next_state = step.next_state;
  assign dout       = step.result[DATA_W-1:0];

  if (DATA_W < MAX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^step.result[MAX_W-1:DATA_W];
  end

endmodule

// File: rtl/scrambler_par.sv
// Parallel self-synchronous 10GBASE-R scrambler/descrambler with a registered
// valid/ready output stage, low-power hold, per-word bypass and runtime seed load.
//   CLK, RST_N          : clock, async active-low reset
//   hold                : freezes LFSR and output stage, blocks input
//   seed_load, seed_val : one-cycle LFSR load (wins over a concurrent update)
//   in_data/in_bypass/in_valid/in_ready : input word handshake
//   out_data/out_valid/out_ready        : registered output handshake
//   lfsr_state          : current LFSR state (debug)
module scrambler_par
  import scrambler_pkg::*;
#(
  parameter int    DATA_W     = 64,
  parameter bit    DESCRAMBLE = 1'b0,
  parameter bit    REVERSE    = 1'b0,
  parameter lfsr_t SEED       = LFSR_SEED_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              hold,
  input  logic              seed_load,
  input  lfsr_t             seed_val,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bypass,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output lfsr_t             lfsr_state
);

  lfsr_t             lfsr, lfsr_next;
  logic [DATA_W-1:0] wire_in, wire_out, core_res;
  logic              accept;

  // With REVERSE the MSB is first on the wire; flip into/out of wire order.
  for (genvar g = 0; g < DATA_W; g++) begin : g_bits
    if (REVERSE) begin : g_rev
      assign wire_in[g]  = in_data[DATA_W-1-g];
      assign core_res[g] = wire_out[DATA_W-1-g];
    end else begin : g_fwd
      assign wire_in[g]  = in_data[g];
      assign core_res[g] = wire_out[g];
    end
  end

  scrambler_core #(
    .DATA_W     (DATA_W),
    .DESCRAMBLE (DESCRAMBLE)
  ) u_core (
    .state      (lfsr),
    .din        (wire_in),
    .next_state (lfsr_next),
    .dout       (wire_out)
  );

  // hold is folded into in_ready so accept needs no separate hold term.
  assign in_ready   = (~out_valid | out_ready) & ~hold;
  assign accept     = in_valid & in_ready;
  assign lfsr_state = lfsr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= seed_val;
    end else if (accept && !in_bypass) begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= in_bypass ? in_data : core_res;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready && !hold) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
